// File: rtl/stable_matching_seq.sv
// stable_matching_seq: sequential Gale-Shapley engine, one proposal committed per clock over a latched preference set.
// Define STABLE_MATCHING_STATS_EN to build the saturating proposals_rejected counter (tied to 0 otherwise).
module stable_matching_seq #(
    parameter int S        = 10,
    parameter int R        = 10,
    parameter int Ks       = 10,
    parameter int Kr       = 10,
    parameter int MAX_ITER = S * Ks
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [R*Kr*$clog2(S)+S*Ks*$clog2(R)-1:0] g,
    output logic                                     busy,
    output logic                                     done,
    output logic [R*$clog2(S):0]                     o,
    output logic [R-1:0]                             r_matched,
    output logic [$clog2(MAX_ITER+1)-1:0]            iter_count,
    output logic [15:0]                              proposals_rejected
);
    localparam int LOGS = $clog2(S);
    localparam int LOGR = $clog2(R);
    localparam int RPW  = R * Kr * LOGS;
    localparam int GW   = RPW + S * Ks * LOGR;
    localparam int IW   = $clog2(MAX_ITER + 1);
    localparam int PW   = $clog2(Ks + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic [PW-1:0]   pc_q [S];
    logic [PW-1:0]   pc_d [S];
    logic [S-1:0]    s_matched_q, s_matched_d;
    logic [LOGS-1:0] match_q [R];
    logic [LOGS-1:0] match_d [R];
    logic [R-1:0]    r_matched_q, r_matched_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic            finish_q, finish_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            accept_s;
    logic            rejected_s;
    logic            found_s;
    logic [LOGS-1:0] cand_s;
    logic [LOGR-1:0] r_prop_s;
    logic            in_range_s;
    logic            held_s;
    logic [LOGS-1:0] holder_s;
    int              rank_new_s;
    int              rank_old_s;

    assign accept_s = start && (state_q != RUN);

    // Candidate selection, its next preference entry and both ranks at the targeted receiver.
    always_comb begin
        found_s    = 1'b0;
        cand_s     = '0;
        r_prop_s   = '0;
        rank_new_s = Kr;
        rank_old_s = Kr;
        for (int i = S - 1; i >= 0; i--) begin
            cand_s  = (pc_q[i] != '0 && !s_matched_q[i]) ? LOGS'(i) : cand_s;
            found_s = found_s | (pc_q[i] != '0 && !s_matched_q[i]);
        end
        for (int i = 0; i < S; i++) begin
            for (int j = 0; j < Ks; j++) begin
                r_prop_s = (LOGS'(i) == cand_s && PW'(Ks - j) == pc_q[i]) ?
                           g_q[RPW + LOGR*(Ks*i + j) +: LOGR] : r_prop_s;
            end
        end
        in_range_s = (int'(r_prop_s) < R);
        held_s     = in_range_s ? r_matched_q[r_prop_s] : 1'b0;
        holder_s   = in_range_s ? match_q[r_prop_s] : '0;
        for (int i = 0; i < R; i++) begin
            for (int j = Kr - 1; j >= 0; j--) begin
                rank_new_s = (LOGR'(i) == r_prop_s && g_q[LOGS*(Kr*i + j) +: LOGS] == cand_s)   ? j : rank_new_s;
                rank_old_s = (LOGR'(i) == r_prop_s && g_q[LOGS*(Kr*i + j) +: LOGS] == holder_s) ? j : rank_old_s;
            end
        end
    end

    // Next-state logic: accept a run, commit one proposal, or terminate.
    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        pc_d        = pc_q;
        s_matched_d = s_matched_q;
        match_d     = match_q;
        r_matched_d = r_matched_q;
        iter_d      = iter_q;
        finish_d    = finish_q;
        busy_d      = busy_q;
        done_d      = done_q;
        rejected_s  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    g_d         = g;
                    for (int i = 0; i < S; i++) pc_d[i] = PW'(Ks);
                    for (int i = 0; i < R; i++) match_d[i] = '0;
                    s_matched_d = '0;
                    r_matched_d = '0;
                    iter_d      = '0;
                    finish_d    = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (!found_s || iter_q == IW'(MAX_ITER)) begin
                    state_d  = DONE;
                    finish_d = !found_s;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    pc_d[cand_s] = pc_q[cand_s] - PW'(1);
                    iter_d       = iter_q + IW'(1);
                    if (!in_range_s) begin
                        rejected_s = 1'b1;
                    end else if (!held_s) begin
                        match_d[r_prop_s]     = cand_s;
                        r_matched_d[r_prop_s] = 1'b1;
                        s_matched_d[cand_s]   = 1'b1;
                    end else if (rank_new_s < rank_old_s) begin
                        // The displaced suitor keeps its pc and resumes from its next entry.
                        match_d[r_prop_s]     = cand_s;
                        s_matched_d[holder_s] = 1'b0;
                        s_matched_d[cand_s]   = 1'b1;
                        rejected_s            = 1'b1;
                    end else begin
                        rejected_s = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            g_q         <= '0;
            for (int i = 0; i < S; i++) pc_q[i] <= '0;
            for (int i = 0; i < R; i++) match_q[i] <= '0;
            s_matched_q <= '0;
            r_matched_q <= '0;
            iter_q      <= '0;
            finish_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            pc_q        <= pc_d;
            match_q     <= match_d;
            s_matched_q <= s_matched_d;
            r_matched_q <= r_matched_d;
            iter_q      <= iter_d;
            finish_q    <= finish_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign r_matched  = r_matched_q;
    assign iter_count = iter_q;

    // Pack the per-receiver matches and the finish flag.
    always_comb begin
        o = '0;
        for (int i = 0; i < R; i++) o[LOGS*i +: LOGS] = match_q[i];
        o[R*LOGS] = finish_q;
    end

`ifdef STABLE_MATCHING_STATS_EN
    logic [15:0] rej_q;

    // Saturating count of rejections and displacements in the current run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_q <= 16'd0;
        end else if (accept_s) begin
            rej_q <= 16'd0;
        end else if (rejected_s && rej_q != 16'hFFFF) begin
            rej_q <= rej_q + 16'd1;
        end else begin
            rej_q <= rej_q;
        end
    end

    assign proposals_rejected = rej_q;
`else
    logic unused_stats_s;
    assign unused_stats_s     = accept_s ^ rejected_s;
    assign proposals_rejected = 16'd0;
`endif

endmodule

// File: tb/tb_stable_matching_seq.sv
// Randomized bench for stable_matching_seq: three instances (2x2, 2x2 capped at 2, 3x3 with incomplete lists)
// checked against a Gale-Shapley reference model plus directed cases.
module tb_stable_matching_seq;
`ifdef STABLE_MATCHING_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [23:0] DISJ = 24'h000060;
    localparam logic [23:0] DISP = 24'h0000A1;
    localparam logic [23:0] REJ  = 24'h0000A2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_c = 1'b0, start_b = 1'b0;
    logic [7:0]  g_a = '0, g_c = '0;
    logic [23:0] g_b = '0;
    logic        busy_a, busy_c, busy_b, done_a, done_c, done_b;
    logic [2:0]  o_a, o_c;
    logic [6:0]  o_b;
    logic [1:0]  rm_a, rm_c;
    logic [2:0]  rm_b;
    logic [2:0]  it_a, it_b;
    logic [1:0]  it_c;
    logic [15:0] rej_a, rej_c, rej_b;

    stable_matching_seq #(.S(2), .R(2), .Ks(2), .Kr(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .g(g_a), .busy(busy_a), .done(done_a),
        .o(o_a), .r_matched(rm_a), .iter_count(it_a), .proposals_rejected(rej_a));
    stable_matching_seq #(.S(2), .R(2), .Ks(2), .Kr(2), .MAX_ITER(2)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .g(g_c), .busy(busy_c), .done(done_c),
        .o(o_c), .r_matched(rm_c), .iter_count(it_c), .proposals_rejected(rej_c));
    stable_matching_seq #(.S(3), .R(3), .Ks(2), .Kr(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .g(g_b), .busy(busy_b), .done(done_b),
        .o(o_b), .r_matched(rm_b), .iter_count(it_b), .proposals_rejected(rej_b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_in(input int which, input logic [23:0] gv, input logic st);
        case (which)
            0:       begin g_a = gv[7:0]; start_a = st; end
            1:       begin g_c = gv[7:0]; start_c = st; end
            default: begin g_b = gv;      start_b = st; end
        endcase
    endtask

    task automatic read_out(input int which, output longint ro, output longint rrm, output longint rit,
                            output longint rrej, output longint rbusy, output longint rdone);
        case (which)
            0:       begin ro = o_a; rrm = rm_a; rit = it_a; rrej = rej_a; rbusy = busy_a; rdone = done_a; end
            1:       begin ro = o_c; rrm = rm_c; rit = it_c; rrej = rej_c; rbusy = busy_c; rdone = done_c; end
            default: begin ro = o_b; rrm = rm_b; rit = it_b; rrej = rej_b; rbusy = busy_b; rdone = done_b; end
        endcase
    endtask

    // Reference model: plain Gale-Shapley with a per-suitor "next choice" index.
    int sp [4][4];
    int rp [4][4];

    function automatic int rank_of(input int r, input int s, input int nkr);
        for (int j = 0; j < nkr; j++) if (rp[r][j] == s) return j;
        return nkr;
    endfunction

    task automatic ref_run(input int which, input logic [23:0] gv, output longint e_o, output longint e_rm,
                           output int e_p, output int e_rej);
        int ns, nr, nks, nkr, ls, lr, maxit, s, r;
        int nxt [4];
        int fi [4];
        bit eng [4];
        bit fin;
        if (which == 2) begin ns = 3; nr = 3; nks = 2; nkr = 2; ls = 2; lr = 2; maxit = 6; end
        else begin ns = 2; nr = 2; nks = 2; nkr = 2; ls = 1; lr = 1; maxit = (which == 1) ? 2 : 4; end
        for (int i = 0; i < nr; i++)
            for (int j = 0; j < nkr; j++) rp[i][j] = int'(gv >> (ls*(nkr*i + j))) & ((1 << ls) - 1);
        for (int i = 0; i < ns; i++)
            for (int j = 0; j < nks; j++) sp[i][j] = int'(gv >> (nr*nkr*ls + lr*(nks*i + j))) & ((1 << lr) - 1);
        for (int i = 0; i < 4; i++) begin nxt[i] = 0; fi[i] = -1; eng[i] = 1'b0; end
        e_p = 0; e_rej = 0; fin = 1'b0;
        for (int step = 0; step < 64; step++) begin
            s = -1;
            for (int i = ns - 1; i >= 0; i--) if (!eng[i] && nxt[i] < nks) s = i;
            if (s < 0) begin fin = 1'b1; break; end
            if (e_p == maxit) break;
            r = sp[s][nxt[s]];
            nxt[s]++;
            e_p++;
            if (r >= nr) e_rej++;
            else if (fi[r] < 0) begin fi[r] = s; eng[s] = 1'b1; end
            else if (rank_of(r, s, nkr) < rank_of(r, fi[r], nkr)) begin
                eng[fi[r]] = 1'b0; fi[r] = s; eng[s] = 1'b1; e_rej++;
            end else e_rej++;
        end
        e_o = 0; e_rm = 0;
        for (int i = 0; i < nr; i++) begin
            if (fi[i] >= 0) begin e_o |= longint'(fi[i]) << (ls*i); e_rm |= longint'(1) << i; end
        end
        if (fin) e_o |= longint'(1) << (nr*ls);
    endtask

    // Start one run, scramble g after acceptance, optionally pulse start mid-run; returns cycles to done.
    task automatic go(input int which, input logic [23:0] gv, input bit pulse, output int lat);
        longint ro, rrm, rit, rrej, rbusy, rdone;
        @(negedge clk);
        set_in(which, gv, 1'b1);
        @(posedge clk);
        #1;
        set_in(which, 24'($urandom), 1'b0);
        read_out(which, ro, rrm, rit, rrej, rbusy, rdone);
        check_eq("accept_busy", rbusy, 1);
        check_eq("accept_done", rdone, 0);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            if (pulse && k == 1) set_in(which, 24'($urandom), 1'b1);
            @(posedge clk);
            #1;
            if (pulse && k == 1) set_in(which, 24'($urandom), 1'b0);
            read_out(which, ro, rrm, rit, rrej, rbusy, rdone);
            if (rdone == 1) begin lat = k; break; end
        end
        if (lat == 0) check_eq("done_timeout", 0, 1);
    endtask

    task automatic run_model_check(input int which, input logic [23:0] gv, input bit pulse);
        longint e_o, e_rm, ro, rrm, rit, rrej, rbusy, rdone;
        int e_p, e_rej, lat;
        ref_run(which, gv, e_o, e_rm, e_p, e_rej);
        go(which, gv, pulse, lat);
        read_out(which, ro, rrm, rit, rrej, rbusy, rdone);
        check_eq("latency", lat, e_p + 1);
        check_eq("o", ro, e_o);
        check_eq("r_matched", rrm, e_rm);
        check_eq("iter_count", rit, e_p);
        check_eq("rejected", rrej, STATS ? e_rej : 0);
        check_eq("busy_end", rbusy, 0);
    endtask

    task automatic hand_check(input string tag, input int which, input longint x_o, input longint x_rm,
                              input longint x_it, input longint x_rej);
        longint ro, rrm, rit, rrej, rbusy, rdone;
        read_out(which, ro, rrm, rit, rrej, rbusy, rdone);
        check_eq({tag, "_o"}, ro, x_o);
        check_eq({tag, "_rm"}, rrm, x_rm);
        check_eq({tag, "_it"}, rit, x_it);
        check_eq({tag, "_rej"}, rrej, x_rej);
    endtask

    initial begin
        int lat;
        #1 rst = 1'b1;
        #2;
        for (int w = 0; w < 3; w++) hand_check("reset", w, 0, 0, 0, 0);
        check_eq("reset_busy", longint'(busy_a | busy_b | busy_c), 0);
        check_eq("reset_done", longint'(done_a | done_b | done_c), 0);
        @(negedge clk);
        rst = 1'b0;

        run_model_check(0, DISJ, 1'b0);
        hand_check("disjoint", 0, 3'b110, 2'b11, 2, 0);
        run_model_check(0, DISP, 1'b0);
        hand_check("displace", 0, 3'b101, 2'b11, 3, STATS ? 1 : 0);
        run_model_check(0, REJ, 1'b0);
        hand_check("reject", 0, 3'b110, 2'b11, 3, STATS ? 1 : 0);
        run_model_check(1, DISP, 1'b0);
        hand_check("cap", 1, 3'b001, 2'b01, 2, STATS ? 1 : 0);

        run_model_check(0, DISJ, 1'b1);
        hand_check("start_in_run", 0, 3'b110, 2'b11, 2, 0);

        // Asynchronous reset in the middle of a run, then a clean rerun.
        @(negedge clk);
        set_in(0, DISP, 1'b1);
        @(posedge clk);
        #1 set_in(0, DISP, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        hand_check("midrst", 0, 0, 0, 0, 0);
        check_eq("midrst_busy", longint'(busy_a), 0);
        check_eq("midrst_done", longint'(done_a), 0);
        @(negedge clk);
        rst = 1'b0;
        run_model_check(0, DISP, 1'b0);
        hand_check("rerun", 0, 3'b101, 2'b11, 3, STATS ? 1 : 0);

        // start held high: done, then exactly one re-acceptance on the following edge.
        @(negedge clk);
        set_in(0, DISP, 1'b1);
        lat = 0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk);
            #1;
            if (done_a) begin lat = k; break; end
        end
        check_eq("held_lat", lat, 5);
        @(posedge clk);
        #1;
        check_eq("held_rerun_busy", longint'(busy_a), 1);
        check_eq("held_rerun_done", longint'(done_a), 0);
        set_in(0, DISP, 1'b0);
        lat = 0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk);
            #1;
            if (done_a) begin lat = k; break; end
        end
        check_eq("held_second_lat", lat, 4);

        for (int n = 0; n < 40; n++) begin
            run_model_check(0, 24'($urandom), n[0]);
            run_model_check(1, 24'($urandom), 1'b0);
            run_model_check(2, 24'($urandom), n[1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
